tt_sweep_ctrl: RTL and testbench
================================

// Module: tt_sweep_ctrl
// PURPOSE
//  Sequencer for a small combinational block under test (3-input `example`, y = f(a,b,c)).
//  On start, drives every input combination in ascending order and waits a settle window per vector.
//  Samples y into a truth-table register and compares it against an expected table.
//  Reports pass/fail and a mismatch count. Sits beside the combinational block in self-checking builds.
// PARAMETERS
//  N_IN     3      number of DUT inputs; table depth is 2**N_IN
//  SETTLE   1      cycles dut_in is held before y is sampled (>=1)
// PORTS
//  clk           in   1            single clock, rising edge
//  reset         in   1            synchronous, active-high
//  start         in   1            request a sweep; honoured only in IDLE
//  expected      in   2**N_IN      expected table, bit i = f(i); captured when start is accepted
//  dut_in        out  N_IN         drives DUT inputs, MSB = a ... LSB = c
//  dut_y         in   1            DUT output
//  busy          out  1            high while a sweep is in progress
//  done          out  1            one-cycle pulse when a sweep completes
//  tt            out  2**N_IN      captured truth table, bit i = y sampled with dut_in == i
//  pass          out  1            tt == expected, valid from the done cycle
//  mismatch_cnt  out  $clog2(2**N_IN+1)  popcount(tt ^ expected)
// BEHAVIOUR
//  Reset: state = IDLE; dut_in, busy, done, tt, pass, mismatch_cnt are all 0; idx = 0; cnt = 0.
//  IDLE:
//   - start = 1 at an edge -> WAIT; idx = 0; cnt = 0; latch expected; clear tt.
//   - start = 0 -> stay in IDLE; results hold their last values.
//  WAIT:
//   - dut_in = idx; busy = 1.
//   - cnt increments each cycle; after SETTLE cycles in WAIT -> SAMPLE.
//  SAMPLE (1 cycle):
//   - dut_in = idx still; tt[idx] <= dut_y at the closing edge.
//   - If idx == 2**N_IN-1 -> DONE; else idx++, cnt = 0, -> WAIT.
//  DONE (1 cycle):
//   - done = 1, busy = 0.
//   - pass and mismatch_cnt are registered on entry, so they are valid in this cycle.
//   - Next state is IDLE unconditionally.
//  Latency: each vector takes SETTLE+1 cycles. done is high exactly 2**N_IN*(SETTLE+1) cycles
//   after the start-accepting edge (16 cycles for the defaults).
//  dut_in changes only on the WAIT entry edge; it is never changed in the sample cycle.
//   After DONE it holds the last vector (all ones).
//  start outside IDLE (WAIT/SAMPLE/DONE) is ignored; it is not queued.
//   Start must be re-asserted in IDLE to run again.
//  idx is an N_IN-bit counter. The terminal compare is on all-ones, so no wrap-around occurs mid-sweep.
//  Reset mid-sweep has priority over everything. Next cycle: IDLE with all outputs 0; partial tt discarded.
//  tt, pass and mismatch_cnt are stable from DONE until the next accepted start, which clears tt.
//   pass and mismatch_cnt keep their old values until the next DONE.
// STRUCTURE
//  Package tt_sweep_pkg: state enum {IDLE, WAIT, SAMPLE, DONE}, and a popcount function sized by N_IN.
//  Single module: one state register, idx/cnt counters, and a result block. No sub-module is warranted.
// TESTING (bench models DUT as y = a&b | c -> table 8'hEA)
//  1. reset, start pulse, expected=8'hEA
//     -> dut_in steps 0..7, each held 2 cycles; done 16 cycles after accept; tt=8'hEA, pass=1, mismatch_cnt=0.
//  2. expected=8'hEB
//     -> tt=8'hEA, pass=0, mismatch_cnt=1; done still a single-cycle pulse.
//  3. start held high for the whole sweep, including the DONE cycle
//     -> exactly one sweep runs, then a second begins only from IDLE (gap of 1 cycle after done).
//  4. reset asserted while idx=4 in WAIT
//     -> next cycle busy=0, dut_in=0, tt=0, done never pulses; a fresh start then completes normally.
//  5. SETTLE=3 build
//     -> each vector held 4 cycles; done 32 cycles after accept; dut_y sampled only in SAMPLE
//        (glitch injected during WAIT has no effect).
//  6. two consecutive sweeps with different expected values
//     -> tt cleared on the second accept; pass/mismatch_cnt update only at the second done.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared state encodings and helpers for the truth-table sweep controller
package tt_sweep_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Widest table the popcount helper covers (N_IN up to 6).
    localparam int MAX_DEPTH = 64;

    function automatic int popcount(input logic [MAX_DEPTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tt_sweep_ctrl.sv
// rtl/tt_sweep_ctrl.sv - exhaustive input sweep of a combinational block with truth-table compare
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [2**N_IN-1:0]               expected,
    output logic [N_IN-1:0]                  dut_in,
    input  logic                             dut_y,
    output logic                             busy,
    output logic                             done,
    output logic [2**N_IN-1:0]               tt,
    output logic                             pass,
    output logic [$clog2(2**N_IN+1)-1:0]     mismatch_cnt
);

    localparam int DEPTH = 2**N_IN;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

    logic [1:0]             state_q, state_d;
    logic [N_IN-1:0]        idx_q, idx_d;
    logic [SW-1:0]          cnt_q, cnt_d;
    logic [DEPTH-1:0]       exp_q, exp_d;
    logic [DEPTH-1:0]       tt_q, tt_d;
    logic                   pass_q, pass_d;
    logic [CNT_W-1:0]       mm_q, mm_d;
    logic [MAX_DEPTH-1:0]   diff_ext;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        tt_d     = tt_q;
        pass_d   = pass_q;
        mm_d     = mm_q;
        diff_ext = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    idx_d   = '0;
                    cnt_d   = '0;
                    exp_d   = expected;
                    tt_d    = '0;
                end
            end
            S_WAIT: begin
                if (cnt_q == SW'(SETTLE-1)) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                tt_d[idx_q] = dut_y;
                if (idx_q == LAST_IDX) begin
                    // Results use the table including the bit captured on this edge.
                    state_d                 = S_DONE;
                    diff_ext[DEPTH-1:0]     = tt_d ^ exp_q;
                    pass_d                  = (tt_d == exp_q);
                    mm_d                    = CNT_W'(popcount(diff_ext));
                end else begin
                    state_d = S_WAIT;
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            pass_q  <= 1'b0;
            mm_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            pass_q  <= pass_d;
            mm_q    <= mm_d;
        end
    end

    assign dut_in       = idx_q;
    assign busy         = (state_q == S_WAIT) || (state_q == S_SAMPLE);
    assign done         = (state_q == S_DONE);
    assign tt           = tt_q;
    assign pass         = pass_q;
    assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb/tb_tt_sweep_ctrl.sv - scoreboard bench for tt_sweep_ctrl at SETTLE=1 and SETTLE=3
module tb_tt_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit fin [2];

    typedef struct {
        logic [7:0] tt;
        logic       pass;
        logic [3:0] mm;
    } exp_t;

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s inst%0d got %0h want %0h at %0t", name, g, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int S = (g == 0) ? 1 : 3;
        localparam int L = 8 * (S + 1);

        logic       reset, start, dut_y, busy, done, pass;
        logic [7:0] expected, tt;
        logic [2:0] dut_in;
        logic [3:0] mismatch_cnt;

        // Block-under-test function and optional glitch during settle windows.
        logic [7:0] tbl     = 8'hEA;
        logic       glitch  = 1'b0;
        logic       wait_ph = 1'b0;

        int   t   = 0;
        int   acc = 0;
        bit   act = 1'b0;
        exp_t sb [$];

        logic [7:0] h_tt   = '0;
        logic       h_pass = 1'b0;
        logic [3:0] h_mm   = '0;
        logic [2:0] h_in   = '0;

        assign dut_y = tbl[dut_in] ^ (glitch & wait_ph);

        tt_sweep_ctrl #(.N_IN(3), .SETTLE(S)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .start        (start),
            .expected     (expected),
            .dut_in       (dut_in),
            .dut_y        (dut_y),
            .busy         (busy),
            .done         (done),
            .tt           (tt),
            .pass         (pass),
            .mismatch_cnt (mismatch_cnt)
        );

        always @(posedge clk) begin : model
            exp_t e;
            t++;
            if (reset) begin
                act    = 1'b0;
                sb.delete();
                h_tt   = '0;
                h_pass = 1'b0;
                h_mm   = '0;
                h_in   = '0;
            end else if (start && (!act || t >= acc + L + 2)) begin
                e.tt   = tbl;
                e.pass = (tbl == expected);
                e.mm   = 4'($countones(tbl ^ expected));
                sb.push_back(e);
                acc = t;
                act = 1'b1;
            end
        end

        always @(negedge clk) begin : monitor
            int   c;
            exp_t e;
            c = t - acc;
            wait_ph = act && (c >= 0) && (c < L) && ((c % (S + 1)) != S);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", g, 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", g, c, L);
                    chk("tt", g, tt, e.tt);
                    chk("pass", g, pass, e.pass);
                    chk("mismatch_cnt", g, mismatch_cnt, e.mm);
                    h_tt   = e.tt;
                    h_pass = e.pass;
                    h_mm   = e.mm;
                    h_in   = 3'd7;
                end
            end
            if (act && c >= 0 && c < L) begin
                chk("busy_sweep", g, busy, 1);
                chk("done_sweep", g, done, 0);
                chk("dut_in_sweep", g, dut_in, c / (S + 1));
                chk("pass_hold", g, pass, h_pass);
                chk("mm_hold", g, mismatch_cnt, h_mm);
            end else if (act && c == L) begin
                chk("done_pulse", g, done, 1);
                chk("busy_done", g, busy, 0);
                chk("dut_in_done", g, dut_in, 7);
            end else begin
                chk("busy_idle", g, busy, 0);
                chk("done_idle", g, done, 0);
                chk("dut_in_idle", g, dut_in, h_in);
                chk("tt_idle", g, tt, h_tt);
                chk("pass_idle", g, pass, h_pass);
                chk("mm_idle", g, mismatch_cnt, h_mm);
            end
        end

        task automatic sweep(input logic [7:0] f, input logic [7:0] ex, input logic gl);
            @(negedge clk);
            tbl      = f;
            expected = ex;
            glitch   = gl;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (L + 2) @(negedge clk);
        endtask

        initial begin : driver
            logic [7:0] f, ex;
            reset    = 1'b1;
            start    = 1'b0;
            expected = '0;
            repeat (3) @(negedge clk);
            reset = 1'b0;

            sweep(8'hEA, 8'hEA, 1'b0);
            sweep(8'hEA, 8'hEB, 1'b0);

            // start held across two full sweeps and the DONE cycle in between
            @(negedge clk);
            tbl      = 8'hEA;
            expected = 8'h6A;
            start    = 1'b1;
            repeat (2 * L + 4) @(negedge clk);
            start = 1'b0;
            repeat (L + 4) @(negedge clk);

            // reset while the sweep sits in WAIT for vector 4
            tbl      = 8'hEA;
            expected = 8'hEA;
            glitch   = 1'b1;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (4 * (S + 1)) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            repeat (3) @(negedge clk);

            sweep(8'hEA, 8'hEA, 1'b1);

            for (int i = 0; i < 8; i++) begin
                f  = 8'($urandom);
                ex = ($urandom_range(0, 1) == 1) ? f : (f ^ 8'($urandom));
                repeat ($urandom_range(0, 3)) @(negedge clk);
                sweep(f, ex, 1'($urandom_range(0, 1)));
            end
            fin[g] = 1'b1;
        end
    end

    initial begin
        for (int k = 0; k < 20000 && !(fin[0] && fin[1]); k++) begin
            @(negedge clk);
        end
        chk("timeout", 0, {31'd0, fin[0] && fin[1]}, 32'd1);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
